pc_sequencer: RTL

Fetch sequencer that owns the program counter register and drives the instruction-memory fetch handshake. It holds the current PC and issues a request to instruction memory. It presents the returned instruction to the decode/control path. On each retire it selects the next PC from sequential, branch, jump, jump-register or exception-vector sources.

---
 rtl/pc_sequencer_if.sv | 23 ++
 rtl/pc_sequencer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch bus between pc_sequencer (master) and instruction memory (slave).
interface pc_sequencer_if #(
  parameter int unsigned INSTRUCTION_WIDTH = 32
);
  logic                         imem_req;
  logic [INSTRUCTION_WIDTH-1:0] imem_addr;
  logic                         imem_ready;
  logic [INSTRUCTION_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch sequencer: owns the PC, runs the imem fetch handshake and selects the next PC on retire.
// Optional fetch watchdog enabled by defining PC_SEQ_FETCH_TIMEOUT_EN.
module pc_sequencer #(
  parameter int unsigned                  INSTRUCTION_WIDTH = 32,
  parameter logic [INSTRUCTION_WIDTH-1:0] RESET_VECTOR      = 32'h0000_0000,
  parameter logic [INSTRUCTION_WIDTH-1:0] EXC_VECTOR        = 32'h8000_0180,
  parameter int unsigned                  TIMEOUT_CYCLES    = 15
) (
  input  logic                         CLK,
  input  logic                         RST,
  pc_sequencer_if.master               imem,
  output logic [INSTRUCTION_WIDTH-1:0] instr,
  output logic                         instr_valid,
  output logic [INSTRUCTION_WIDTH-1:0] pc,
  input  logic                         stall,
  input  logic                         branch_taken,
  input  logic [INSTRUCTION_WIDTH-1:0] branch_offset,
  input  logic                         jump,
  input  logic [25:0]                  jump_index,
  input  logic                         jump_reg,
  input  logic [INSTRUCTION_WIDTH-1:0] reg_target,
  input  logic                         exception,
  output logic [INSTRUCTION_WIDTH-1:0] epc,
  output logic                         addr_err,
  output logic                         bus_err
);

  // The jump target concatenation assumes a 32-bit word with a 26-bit index field.
  if (INSTRUCTION_WIDTH != 32 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("pc_sequencer: INSTRUCTION_WIDTH must be 32 and TIMEOUT_CYCLES at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE
  } state_t;

  state_t                         state;
  logic                           req_q;
  logic [INSTRUCTION_WIDTH-1:0]   pc4;

  assign pc4            = pc + INSTRUCTION_WIDTH'(4);
  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc;

`ifdef PC_SEQ_FETCH_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  // Counts unanswered FETCH cycles; cleared whenever the fetch completes or restarts.
  assign tmo_hit = (state == S_FETCH) && !imem.imem_ready && (tmo_cnt == TMO_LAST);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tmo_cnt <= '0;
    end else if (state != S_FETCH || imem.imem_ready || tmo_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end
`else
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= S_IDLE;
      pc          <= RESET_VECTOR;
      instr       <= '0;
      epc         <= '0;
      req_q       <= 1'b0;
      instr_valid <= 1'b0;
      addr_err    <= 1'b0;
`ifdef PC_SEQ_FETCH_TIMEOUT_EN
      bus_err     <= 1'b0;
`endif
    end else begin
      addr_err <= 1'b0;
`ifdef PC_SEQ_FETCH_TIMEOUT_EN
      bus_err  <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          state <= S_FETCH;
          req_q <= 1'b1;
        end

        S_FETCH: begin
          if (imem.imem_ready) begin
            instr       <= imem.imem_rdata;
            instr_valid <= 1'b1;
            req_q       <= 1'b0;
            state       <= S_ISSUE;
          end
`ifdef PC_SEQ_FETCH_TIMEOUT_EN
          else if (tmo_hit) begin
            // Stay in FETCH and refetch from the exception vector.
            pc      <= EXC_VECTOR;
            epc     <= pc;
            bus_err <= 1'b1;
          end
`endif
        end

        S_ISSUE: begin
          if (!stall) begin
            instr_valid <= 1'b0;
            req_q       <= 1'b1;
            state       <= S_FETCH;
            if (exception) begin
              pc  <= EXC_VECTOR;
              epc <= pc;
            end else if (jump_reg && (reg_target[1:0] != 2'b00)) begin
              pc       <= EXC_VECTOR;
              epc      <= pc;
              addr_err <= 1'b1;
            end else if (jump_reg) begin
              pc <= reg_target;
            end else if (jump) begin
              pc <= {pc4[INSTRUCTION_WIDTH-1:28], jump_index, 2'b00};
            end else if (branch_taken) begin
              pc <= pc4 + (branch_offset << 2);
            end else begin
              pc <= pc4;
            end
          end
        end

        default: begin
          state <= S_IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
